// File: rtl/spi_cmd_master.sv
// Register-access SPI master (mode 0, MSB first): one command word becomes one
// frame of {write, addr, data}. The last DATA_W bits sampled from MISO are returned.
module spi_cmd_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk_out,
    output logic              ss_out,
    output logic              mosi_out,
    input  logic              miso_in
);

    localparam int unsigned N     = 1 + ADDR_W + DATA_W;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(N);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [N-1:0]       tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               sclk_q, sclk_d;
    logic               ss_q, ss_d;
    logic               mosi_q, mosi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_d       = div_last ? '0 : div_q + DIV_W'(1);
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        sclk_d      = sclk_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            StIdle: begin
                div_d = '0;
                if (cmd_valid) begin
                    state_d = StSetup;
                    tx_d    = {cmd_write, cmd_addr, {DATA_W{cmd_write}} & cmd_wdata};
                    ss_d    = 1'b0;
                    mosi_d  = cmd_write;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            StSetup: begin
                if (div_last) begin
                    state_d = StShift;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_W-2:0], miso_in};
                end
            end
            StShift: begin
                if (div_last) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = StHold;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d  = bit_q + BIT_W'(1);
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[N-2];
                        end
                    end else begin
                        // miso is stable half a period ahead, so sample it directly
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_W-2:0], miso_in};
                    end
                end
            end
            StHold: begin
                if (div_last) begin
                    state_d     = StGap;
                    ss_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = rx_q;
                end
            end
            StGap: begin
                if (div_last) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign sclk_out  = sclk_q;
    assign ss_out    = ss_q;
    assign mosi_out  = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: random register commands against a slave model
// and a cycle-timing reference; a second CLK_DIV=2 instance checks the fast build.
module tb_spi_cmd_master;

    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int N       = 1 + ADDR_W + DATA_W;
    localparam int T_RSP   = 1 + CLK_DIV * (2 * N + 1);
    localparam int T_RDY   = 1 + CLK_DIV * (2 * N + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              cmd_ready, rsp_valid, busy, sclk_out, ss_out, mosi_out;
    logic [DATA_W-1:0] rsp_rdata;
    logic              miso_in = 1'b0;

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sclk_out(sclk_out), .ss_out(ss_out), .mosi_out(mosi_out), .miso_in(miso_in)
    );

    logic              cmd_valid2 = 1'b0, cmd_write2 = 1'b0;
    logic [ADDR_W-1:0] cmd_addr2  = '0;
    logic [DATA_W-1:0] cmd_wdata2 = '0;
    logic              cmd_ready2, rsp_valid2, busy2, sclk2, ss2, mosi2;
    logic [DATA_W-1:0] rsp_rdata2;
    logic              miso2 = 1'b0;

    spi_cmd_master #(.CLK_DIV(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_write(cmd_write2), .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .sclk_out(sclk2), .ss_out(ss2), .mosi_out(mosi2), .miso_in(miso2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [N-1:0]      frame;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] slave_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: presents bit N-1-k of its word before SCLK rise k.
    logic [N-1:0] s_word;
    logic         s_have = 1'b0, s_prev = 1'b0;
    int           s_rises = 0;
    always @(negedge clk) begin
        if (rst || ss_out) begin
            s_have  = 1'b0;
            s_rises = 0;
            miso_in = 1'b0;
        end else if (!s_have) begin
            s_have  = 1'b1;
            s_word  = (slave_q.size() != 0) ? slave_q.pop_front() : '0;
            miso_in = s_word[N-1];
        end else if (sclk_out && !s_prev) begin
            s_rises++;
            if (s_rises < N) miso_in = s_word[N-1-s_rises];
        end
        s_prev = sclk_out;
    end

    // Monitor: timing reference from acceptance, frame capture, response scoreboard.
    logic              in_frame = 1'b0, b2b = 1'b0, just_done, m_prev_sclk = 1'b0;
    logic              m_prev_ss = 1'b1, e_sclk;
    logic [N-1:0]      got_frame;
    logic [DATA_W-1:0] last_rdata = '0;
    int                acc = 0, rel, r, rises = 0, ss_hi = 0;
    exp_t              e;
    always @(negedge clk) begin
        just_done = 1'b0;
        if (rst) begin
            chk("reset cmd_ready", 32'(cmd_ready), 1);
            chk("reset busy", 32'(busy), 0);
            chk("reset sclk", 32'(sclk_out), 0);
            chk("reset ss", 32'(ss_out), 1);
            chk("reset mosi", 32'(mosi_out), 0);
            chk("reset rsp_valid", 32'(rsp_valid), 0);
            chk("reset rsp_rdata", 32'(rsp_rdata), 0);
            in_frame   = 1'b0;
            b2b        = 1'b0;
            last_rdata = '0;
        end else begin
            if (in_frame) begin
                rel    = cyc - acc + 1;
                r      = rel - 1;
                e_sclk = (r >= CLK_DIV) && (r < CLK_DIV * (2 * N + 1)) && ((r / CLK_DIV) % 2 == 1);
                chk("frame ss", 32'(ss_out), 32'(rel >= T_RSP));
                chk("frame sclk", 32'(sclk_out), 32'(e_sclk));
                chk("frame rsp_valid", 32'(rsp_valid), 32'(rel == T_RSP));
                chk("frame cmd_ready", 32'(cmd_ready), 32'(rel >= T_RDY));
                chk("frame busy", 32'(busy), 32'(rel < T_RDY));
                if (sclk_out && !m_prev_sclk) begin
                    got_frame = {got_frame[N-2:0], mosi_out};
                    rises++;
                end
                if (rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected rsp_valid", 32'(rsp_valid), 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("mosi frame", 32'(got_frame), 32'(e.frame));
                        chk("sclk rise count", 32'(rises), N);
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                        last_rdata = e.rdata;
                    end
                end else begin
                    chk("rsp_rdata held", 32'(rsp_rdata), 32'(last_rdata));
                end
                if (cmd_ready) begin
                    in_frame  = 1'b0;
                    just_done = 1'b1;
                end
            end else begin
                chk("idle cmd_ready", 32'(cmd_ready), 1);
                chk("idle busy", 32'(busy), 0);
                chk("idle ss", 32'(ss_out), 1);
                chk("idle sclk", 32'(sclk_out), 0);
                chk("idle mosi", 32'(mosi_out), 0);
                chk("idle rsp_valid", 32'(rsp_valid), 0);
                chk("idle rsp_rdata held", 32'(rsp_rdata), 32'(last_rdata));
            end
            // Deselect between back-to-back frames: GAP plus the accepting IDLE cycle.
            if (ss_out) ss_hi++;
            else if (m_prev_ss) begin
                if (b2b) chk("back-to-back deselect", 32'(ss_hi), CLK_DIV + 1);
                b2b   = 1'b0;
                ss_hi = 0;
            end
            if (cmd_valid && cmd_ready) begin
                b2b       = just_done;
                in_frame  = 1'b1;
                acc       = cyc + 1;
                rises     = 0;
                got_frame = '0;
            end
        end
        m_prev_sclk = sclk_out;
        m_prev_ss   = ss_out;
    end

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [N-1:0] sw, input bit scribble);
        int   t = 0;
        exp_t x;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready) begin
            t++;
            if (t > 1000) begin
                $display("FAIL accept timeout: cmd_ready stayed 0");
                $fatal(1);
            end
            @(negedge clk);
        end
        x.frame = {w, a, w ? d : 8'h00};
        x.rdata = sw[DATA_W-1:0];
        sb_q.push_back(x);
        slave_q.push_back(sw);
        @(posedge clk);
        #1;
        if (scribble) begin
            repeat ($urandom_range(150, 20)) begin
                cmd_valid = 1'($urandom);
                cmd_write = 1'($urandom);
                cmd_addr  = ADDR_W'($urandom);
                cmd_wdata = DATA_W'($urandom);
                @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        int t = 0;
        cmd_valid = 1'b0;
        while (!cmd_ready && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic dut2_done = 1'b0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(1'b1, 15'h0123, 8'hA5, 24'($urandom), 1'b0);
        idle_gap(5);
        issue(1'b0, 15'h0037, 8'($urandom), {16'($urandom), 8'h5C}, 1'b0);
        idle_gap(3);
        // Back-to-back pair with mid-frame noise on the command inputs.
        issue(1'b1, 15'($urandom), 8'($urandom), 24'($urandom), 1'b1);
        issue(1'b0, 15'($urandom), 8'($urandom), 24'($urandom), 1'b1);
        for (int i = 0; i < 8; i++) begin
            issue(1'($urandom), 15'($urandom), 8'($urandom), 24'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) idle_gap(int'($urandom_range(6, 0)));
        end
        idle_gap(2);
        // Abort a frame at cycle 100.
        issue(1'b1, 15'h5555, 8'h3C, 24'($urandom), 1'b0);
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort ss", 32'(ss_out), 1);
        chk("abort sclk", 32'(sclk_out), 0);
        chk("abort mosi", 32'(mosi_out), 0);
        chk("abort rsp_valid", 32'(rsp_valid), 0);
        chk("abort cmd_ready", 32'(cmd_ready), 1);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, 15'h2AAA, 8'h00, 24'($urandom), 1'b0);
        idle_gap(20);
        chk("scoreboard drained", 32'(sb_q.size()), 0);
        chk("fast build finished", 32'(dut2_done), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // CLK_DIV=2 instance: single write, frame and timing checks.
    initial begin
        int     a2, rel2, last_tr = 0, rises2 = 0;
        logic   p2 = 1'b0, seen = 1'b0;
        logic [N-1:0] f2 = '0;
        @(negedge rst);
        @(posedge clk);
        #1;
        cmd_write2 = 1'b1;
        cmd_addr2  = 15'h7FFF;
        cmd_wdata2 = 8'hFF;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        chk("fast cmd_ready", 32'(cmd_ready2), 1);
        @(posedge clk);
        #1;
        cmd_valid2 = 1'b0;
        a2 = cyc;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            rel2 = cyc - a2 + 1;
            if (sclk2 != p2) begin
                if (last_tr > 0) chk("fast sclk half period", 32'(rel2 - last_tr), 2);
                last_tr = rel2;
                if (sclk2) begin
                    f2 = {f2[N-2:0], mosi2};
                    rises2++;
                end
            end
            p2 = sclk2;
            if (rsp_valid2) begin
                seen = 1'b1;
                chk("fast rsp_valid cycle", 32'(rel2), 99);
                chk("fast mosi frame", 32'(f2), 32'h00FF_FFFF);
                chk("fast rise count", 32'(rises2), N);
                chk("fast rsp_rdata", 32'(rsp_rdata2), 0);
            end
        end
        chk("fast rsp seen", 32'(seen), 1);
        dut2_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1);
    end

endmodule
